// File: rtl/sumador_pkg.sv
// Shared types and constants for the sumador_arbiter slice (FSM states, default widths).
package sumador_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int NREQ_MAX  = 4;
    localparam int IDX_W     = $clog2(NREQ_MAX);

endpackage

// File: rtl/sumador_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping to 0.
module rr_arbiter
    import sumador_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    logic found;
    int   cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (en && !found && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand[IDX_W-1:0];
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sumador_arbiter.sv
// Round-robin shared adder: one operand pair in flight, result held until consumed.
// Optional macro SUMADOR_SAT_EN saturates res_sum to all ones on carry-out.
module sumador_arbiter
    import sumador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_cout,
    output logic [IDX_W-1:0]      res_id,
    output logic                  busy
);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] id_q;
    logic [IDX_W-1:0] gnt_idx;
    logic [NREQ-1:0]  grant;
    logic             arb_en;
    logic             transfer;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum_sel;

    // Grants are suppressed during reset so a held req_valid is never accepted.
    assign arb_en    = (state == S_IDLE) && !rst;
    assign req_ready = grant;
    assign transfer  = |(req_valid & grant);
    assign busy      = (state != S_IDLE);
    assign ptr_next  = (id_q == IDX_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
    assign sum_full  = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        sum_sel = sum_full[WIDTH-1:0];
`ifdef SUMADOR_SAT_EN
        if (sum_full[WIDTH]) begin
            sum_sel = '1;
        end
`endif
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (arb_en),
        .grant (grant),
        .idx   (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (transfer) begin
                        a_q   <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                        b_q   <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                        id_q  <= gnt_idx;
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    res_sum   <= sum_sel;
                    res_cout  <= sum_full[WIDTH];
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    // Pointer moves past the owner only once the result is consumed.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ptr       <= ptr_next;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
